// File: rtl/mul_seq_if.sv
// Handshake and operand/result bus for the sequential multiplier.
interface mul_seq_if #(
    parameter int W = 16
);
    logic           start;
    logic [W-1:0]   din;
    logic           busy;
    logic           done;
    logic [2*W-1:0] pout;

    modport master (output start, din, input  busy, done, pout);
    modport slave  (input  start, din, output busy, done, pout);
endinterface

// File: rtl/mul_seq.sv
// Sequential unsigned multiplier: adds A into the accumulator once per cycle
// while a loadable down-counter holding B runs to zero.
module mul_seq #(
    parameter int W = 16
) (
    input logic     clk,
    input logic     rst_n,
    mul_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LDB, ADD, DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_cnt;
    logic [2*W-1:0] p_acc;
    logic           ld_a;
    logic           ldb;
    logic           decb;
    logic           b_last;

    // The counter reads 1 during the final addition.
    assign b_last = (b_cnt == W'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and strobes; ldb and decb come from disjoint states.
    always_comb begin
        state_nxt = state;
        ld_a      = 1'b0;
        ldb       = 1'b0;
        decb      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    ld_a      = 1'b1;
                    state_nxt = LDB;
                end
            end
            LDB: begin
                ldb       = 1'b1;
                state_nxt = (bus.din == '0) ? DONE : ADD;
            end
            ADD: begin
                decb = 1'b1;
                if (b_last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Multiplicand register, captured on the accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    a_reg <= '0;
        else if (ld_a) a_reg <= bus.din;
    end

    // B down-counter: load wins over decrement, and it never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     b_cnt <= '0;
        else if (ldb)                   b_cnt <= bus.din;
        else if (decb && b_cnt != '0)   b_cnt <= b_cnt - W'(1);
    end

    // Accumulator: cleared on start, one addition of A per ADD cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    p_acc <= '0;
        else if (ld_a) p_acc <= '0;
        else if (decb) p_acc <= p_acc + {{W{1'b0}}, a_reg};
    end

    assign bus.busy = (state == LDB) || (state == ADD);
    assign bus.done = (state == DONE);
    assign bus.pout = p_acc;
endmodule
